// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: RAM handshake states, word type and the
// memory arbiter's grant states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IGRANT,
        DGRANT
    } arbstate_t;

    localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and the data path.
// Data wins ties; a fetch is forced after STARVE_LIMIT data grants in a row.
//
// Handshake: a requester raises xREN/dWEN with address/data stable and holds
// them until its wait output is low. Wait is low for exactly the one
// completion cycle, in which the load output is valid. Dropping the request
// before that cycle aborts the access without a completion.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter word_t       ERR_WORD     = ERR_WORD_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        err,
    output logic [1:0]  dbg_state_o,
    output logic [3:0]  dbg_starve_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arbstate_t   state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        err_q, err_d;

    logic        d_req;
    logic        ram_done;
    logic        ram_err;
    logic        fetch_forced;
    logic [3:0]  starve_inc;
    word_t       ram_word;

    assign d_req        = dREN | dWEN;
    assign ram_done     = (ramstate == ACCESS) || (ramstate == ERROR);
    assign ram_err      = (ramstate == ERROR);
    assign ram_word     = ram_err ? ERR_WORD : ramload;
    assign fetch_forced = iREN && (starve_q == LIMIT);
    assign starve_inc   = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        err_d    = err_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = iREN;
        dwait    = d_req;

        case (state_q)
            IDLE: begin
                if (d_req && !fetch_forced) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT: begin
                // A dropped request is a squash: release the RAM, no completion.
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_done) begin
                        iwait    = 1'b0;
                        iload    = ram_word;
                        state_d  = IDLE;
                        starve_d = '0;
                        err_d    = err_q | ram_err;
                    end
                end
            end
            DGRANT: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ram_done) begin
                        dwait    = 1'b0;
                        dload    = ram_word;
                        state_d  = IDLE;
                        starve_d = iREN ? starve_inc : 4'd0;
                        err_d    = err_q | ram_err;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign err          = err_q;
    assign dbg_state_o  = state_q;
    assign dbg_starve_o = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written multi-cycle
// sequences, then random traffic against a transaction-level model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LIM = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    ramstate_t   ramstate;
    logic [1:0]  dbg_state_o;
    logic [3:0]  dbg_starve_o;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err),
        .dbg_state_o(dbg_state_o), .dbg_starve_o(dbg_starve_o)
    );

    always #5 CLK = ~CLK;

    // RAM responder: BUSY for cur_lat enabled cycles, then ACCESS (or ERROR).
    int    busy_cnt;
    int    cur_lat;
    logic  cur_err;
    logic  use_hash;
    word_t fixed_load;

    function automatic word_t hash(input word_t a);
        return (a ^ 32'hA5A5_1234) + {a[15:0], a[31:16]};
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) busy_cnt <= 0;
        else if ((ramREN || ramWEN) && ramstate == BUSY) busy_cnt <= busy_cnt + 1;
        else busy_cnt <= 0;
    end

    always_comb begin
        if (!(ramREN || ramWEN)) ramstate = FREE;
        else if (busy_cnt >= cur_lat) ramstate = cur_err ? ERROR : ACCESS;
        else ramstate = BUSY;
    end

    assign ramload = use_hash ? hash(ramaddr) : fixed_load;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        cur_lat = 0; cur_err = 1'b0; use_hash = 1'b0; fixed_load = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    typedef struct {
        logic  rst_first;
        logic  fetch;
        logic  re;
        logic  we;
        word_t addr;
        word_t store;
        int    lat;
        logic  rerr;
        word_t rload;
        int    exp_done;
        word_t exp_load;
        logic  exp_ren;
        logic  exp_wen;
        logic  exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic run_row(input vec_t v, input int idx);
        int    done_c;
        logic  w;
        if (v.rst_first) do_reset();
        cur_lat = v.lat; cur_err = v.rerr; use_hash = 1'b0; fixed_load = v.rload;
        iREN = v.fetch; iaddr = v.fetch ? v.addr : 32'h0;
        dREN = v.re; dWEN = v.we; daddr = v.addr; dstore = v.store;
        #1;
        chk($sformatf("row%0d c0 state", idx), 32'(dbg_state_o), 32'(IDLE));
        chk($sformatf("row%0d c0 wait", idx), 32'(v.fetch ? iwait : dwait), 32'd1);
        done_c = -1;
        for (int c = 1; c <= 20 && done_c < 0; c++) begin
            tick();
            #1;
            if (c == 1) begin
                chk($sformatf("row%0d ramREN", idx), 32'(ramREN), 32'(v.exp_ren));
                chk($sformatf("row%0d ramWEN", idx), 32'(ramWEN), 32'(v.exp_wen));
                chk($sformatf("row%0d ramaddr", idx), ramaddr, v.addr);
                chk($sformatf("row%0d ramstore", idx), ramstore, v.we ? v.store : 32'h0);
            end
            w = v.fetch ? iwait : dwait;
            if (!w) begin
                done_c = c;
                chk($sformatf("row%0d load", idx), v.fetch ? iload : dload, v.exp_load);
                chk($sformatf("row%0d other load", idx), v.fetch ? dload : iload, 32'h0);
            end
        end
        chk($sformatf("row%0d done cycle", idx), 32'(done_c), 32'(v.exp_done));
        tick();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        #1;
        chk($sformatf("row%0d back idle", idx), 32'(dbg_state_o), 32'(IDLE));
        chk($sformatf("row%0d err", idx), 32'(err), 32'(v.exp_err));
    endtask

    // Transaction-level reference: who owns the RAM, how many data
    // completions in a row a waiting fetch has watched, sticky error.
    int    m_owner;   // 0 nobody, 1 fetch, 2 data
    int    m_streak;
    logic  m_err;
    logic  i_fin, d_fin;

    task automatic random_phase(input int n);
        logic  e_ren, e_wen, e_iwait, e_dwait, dq, ok;
        word_t e_addr, e_store, e_iload, e_dload, rword;
        int    k;
        do_reset();
        use_hash = 1'b1;
        m_owner = 0; m_streak = 0; m_err = 1'b0;
        i_fin = 1'b0; d_fin = 1'b0;
        for (int cyc = 0; cyc < n; cyc++) begin
            if (cyc > 0) tick();
            if (iREN) begin
                if (i_fin) begin
                    iREN = 1'($urandom_range(0, 1)); iaddr = $urandom;
                end else if ($urandom_range(0, 31) == 0) iREN = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                iREN = 1'b1; iaddr = $urandom;
            end
            if (dREN || dWEN) begin
                if (d_fin || $urandom_range(0, 31) == 0) begin
                    dREN = 1'b0; dWEN = 1'b0;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, 2);
                dREN = (k != 1); dWEN = (k != 0);
                daddr = $urandom; dstore = $urandom;
            end
            cur_lat = $urandom_range(0, 2);
            cur_err = ($urandom_range(0, 15) == 0);
            #1;
            dq = dREN | dWEN;
            ok = (ramstate == ACCESS) || (ramstate == ERROR);
            rword = (ramstate == ERROR) ? 32'hBAD1BAD1 : ramload;
            e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
            e_iload = '0; e_dload = '0; e_iwait = iREN; e_dwait = dq;
            i_fin = 1'b0; d_fin = 1'b0;
            if (m_owner == 1 && iREN) begin
                e_ren = 1'b1; e_addr = iaddr;
                if (ok) begin e_iwait = 1'b0; e_iload = rword; i_fin = 1'b1; end
            end else if (m_owner == 2 && dq) begin
                e_addr = daddr;
                if (dWEN) begin e_wen = 1'b1; e_store = dstore; end
                else e_ren = 1'b1;
                if (ok) begin e_dwait = 1'b0; e_dload = rword; d_fin = 1'b1; end
            end
            chk("rnd ramREN", 32'(ramREN), 32'(e_ren));
            chk("rnd ramWEN", 32'(ramWEN), 32'(e_wen));
            chk("rnd ramaddr", ramaddr, e_addr);
            chk("rnd ramstore", ramstore, e_store);
            chk("rnd iwait", 32'(iwait), 32'(e_iwait));
            chk("rnd dwait", 32'(dwait), 32'(e_dwait));
            chk("rnd iload", iload, e_iload);
            chk("rnd dload", dload, e_dload);
            chk("rnd err", 32'(err), 32'(m_err));
            chk("rnd starve", 32'(dbg_starve_o), 32'(m_streak));
            if ((i_fin || d_fin) && ramstate == ERROR) m_err = 1'b1;
            if (m_owner == 0) begin
                if (dq && !(iREN && m_streak == LIM)) m_owner = 2;
                else if (iREN) m_owner = 1;
            end else if (m_owner == 1) begin
                if (!iREN || i_fin) m_owner = 0;
                if (i_fin) m_streak = 0;
            end else begin
                if (!dq || d_fin) m_owner = 0;
                if (d_fin) m_streak = iREN ? ((m_streak + 1 > LIM) ? LIM : m_streak + 1) : 0;
            end
        end
        tick();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int d_done, i_c;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 2, 1'b0, 32'h2408_0005,
                    3, 32'h2408_0005, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 0, 1'b0, 32'h1234_5678,
                    1, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 1'b0, 32'h0000_1111,
                    2, 32'h0000_1111, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0204, 32'h0, 1, 1'b1, 32'h5555_5555,
                    2, 32'hBAD1_BAD1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 0, 1'b0, 32'h0F0F_0F0F,
                    1, 32'h0F0F_0F0F, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0048, 32'h0, 1, 1'b1, 32'h7777_7777,
                    2, 32'hBAD1_BAD1, 1'b1, 1'b0, 1'b1};

        // Reset state with both requests raised during reset.
        RST = 1'b1;
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h10; daddr = 32'h20; dstore = 32'h30;
        cur_lat = 0; cur_err = 1'b0; use_hash = 1'b0; fixed_load = 32'h9999_9999;
        #1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst state", 32'(dbg_state_o), 32'(IDLE));
        chk("rst ramREN", 32'(ramREN), 32'd0);
        chk("rst ramWEN", 32'(ramWEN), 32'd0);
        chk("rst ramaddr", ramaddr, 32'h0);
        chk("rst iload", iload, 32'h0);
        chk("rst dload", dload, 32'h0);
        chk("rst iwait", 32'(iwait), 32'd1);
        chk("rst dwait", 32'(dwait), 32'd1);
        chk("rst err", 32'(err), 32'd0);
        chk("rst starve", 32'(dbg_starve_o), 32'd0);

        for (int r = 0; r < 6; r++) run_row(vecs[r], r);

        // Asynchronous reset in the middle of a data write (err is set here).
        cur_lat = 15; cur_err = 1'b0;
        dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
        tick();
        #1;
        chk("arst pre ramWEN", 32'(ramWEN), 32'd1);
        chk("arst pre err", 32'(err), 32'd1);
        RST = 1'b1;
        #1;
        chk("arst ramWEN", 32'(ramWEN), 32'd0);
        chk("arst state", 32'(dbg_state_o), 32'(IDLE));
        chk("arst err", 32'(err), 32'd0);
        chk("arst dwait", 32'(dwait), 32'd1);
        tick();
        RST = 1'b0; dWEN = 1'b0;

        // Fetch and read together, zero latency.
        do_reset();
        fixed_load = 32'hCAFE_0001;
        iREN = 1'b1; iaddr = 32'h0000_0080; dREN = 1'b1; daddr = 32'h0000_0300;
        #1;
        tick(); #1;
        chk("both c1 state", 32'(dbg_state_o), 32'(DGRANT));
        chk("both c1 dwait", 32'(dwait), 32'd0);
        chk("both c1 dload", dload, 32'hCAFE_0001);
        chk("both c1 iwait", 32'(iwait), 32'd1);
        chk("both c1 ramaddr", ramaddr, 32'h0000_0300);
        tick();
        dREN = 1'b0;
        #1;
        chk("both c2 state", 32'(dbg_state_o), 32'(IDLE));
        chk("both c2 iwait", 32'(iwait), 32'd1);
        chk("both c2 starve", 32'(dbg_starve_o), 32'd1);
        tick(); #1;
        chk("both c3 state", 32'(dbg_state_o), 32'(IGRANT));
        chk("both c3 iwait", 32'(iwait), 32'd0);
        chk("both c3 iload", iload, 32'hCAFE_0001);
        chk("both c3 ramaddr", ramaddr, 32'h0000_0080);
        tick();
        iREN = 1'b0;
        #1;
        chk("both c4 starve", 32'(dbg_starve_o), 32'd0);

        // Starvation: continuous reads against a pending fetch.
        do_reset();
        fixed_load = 32'h0000_00AA;
        iREN = 1'b1; iaddr = 32'h0000_00C0; dREN = 1'b1; daddr = 32'h0000_0400;
        #1;
        d_done = 0; i_c = -1;
        for (int c = 0; c < 40 && i_c < 0; c++) begin
            if (c > 0) begin tick(); #1; end
            if (dREN && !dwait) d_done++;
            if (!iwait) begin
                i_c = c;
                chk("starve cnt at fetch", 32'(dbg_starve_o), 32'(LIM));
                chk("starve fetch dwait", 32'(dwait), 32'd1);
            end
        end
        chk("starve data completions", 32'(d_done), 32'(LIM));
        chk("starve fetch cycle", 32'(i_c), 32'd9);
        tick(); #1;
        chk("starve cleared", 32'(dbg_starve_o), 32'd0);
        iREN = 1'b0; dREN = 1'b0;
        tick();

        // Fetch squashed while RAM is busy.
        do_reset();
        cur_lat = 15;
        iREN = 1'b1; iaddr = 32'h0000_0044;
        #1;
        tick(); #1;
        chk("abort c1 state", 32'(dbg_state_o), 32'(IGRANT));
        chk("abort c1 ramREN", 32'(ramREN), 32'd1);
        chk("abort c1 iwait", 32'(iwait), 32'd1);
        tick();
        iREN = 1'b0;
        #1;
        chk("abort c2 ramREN", 32'(ramREN), 32'd0);
        chk("abort c2 iload", iload, 32'h0);
        tick(); #1;
        chk("abort c3 state", 32'(dbg_state_o), 32'(IDLE));
        chk("abort c3 starve", 32'(dbg_starve_o), 32'd0);

        random_phase(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
